// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared widths, digit limits and field positions for the stopwatch counter
//
// Purpose : constants shared by stopwatch_counter and bcd_digit_counter.
// Ports   : none (package).
package stopwatch_pkg;

    localparam int BCD_W   = 4;
    localparam int TIME_W  = 24;

    // Largest value a decimal digit or a base-six digit (tens of sec/min) reaches.
    localparam int DEC_MAX = 9;
    localparam int SEX_MAX = 5;

    // LSB position of each digit inside live_time / latched_time.
    localparam int CS_U_LSB  = 0;
    localparam int CS_T_LSB  = 4;
    localparam int SEC_U_LSB = 8;
    localparam int SEC_T_LSB = 12;
    localparam int MIN_U_LSB = 16;
    localparam int MIN_T_LSB = 20;

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - one BCD digit of the stopwatch, wrapping at MAX
//
// Purpose : counts 0..MAX on inc, clears on clr (clr wins), flags carry out.
// Ports   : sys_clk, reset_n (async, active low)
//           clr   - synchronous clear to 0
//           inc   - advance one step this cycle
//           digit - current digit value
//           carry - combinational, inc while digit == MAX (next digit advances)
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = DEC_MAX
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] digit,
    output logic             carry
);

    logic at_max;

    assign at_max = (digit == BCD_W'(MAX));
    assign carry  = inc & at_max;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= at_max ? '0 : digit + BCD_W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - centisecond stopwatch with BCD MM:SS.cc output and stop-event latch
//
// Purpose : clears on count_init rising edge, counts centiseconds while
//           count_enb is high, captures the time on latch_count falling edge.
// Ports   : sys_clk, reset_n (async, active low)
//           count_init   - level, rising edge clears time and prescaler
//           count_enb    - level, high enables counting
//           latch_count  - level, falling edge captures live_time
//           live_time    - BCD {min_t,min_u,sec_t,sec_u,cs_t,cs_u}
//           latched_time - BCD time captured at the last stop event
//           running      - registered count_enb
//           tick         - pulse aligned with each live_time increment
//           overflow     - pulse aligned with the 59:59.99 -> 00:00.00 wrap
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 500000,
    parameter int PRESC_W  = 19
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              count_init,
    input  logic              count_enb,
    input  logic              latch_count,
    output logic [TIME_W-1:0] live_time,
    output logic [TIME_W-1:0] latched_time,
    output logic              running,
    output logic              tick,
    output logic              overflow
);

    logic               init_d;
    logic               latch_d;
    logic               init_rise;
    logic               latch_fall;
    logic [PRESC_W-1:0] presc;
    logic               presc_last;
    logic               tick_now;

    logic [BCD_W-1:0]   d_cs_u, d_cs_t, d_sec_u, d_sec_t, d_min_u, d_min_t;
    logic               c_cs_u, c_cs_t, c_sec_u, c_sec_t, c_min_u, c_min_t;

    assign init_rise  = count_init & ~init_d;
    assign latch_fall = ~latch_count & latch_d;
    assign presc_last = (presc == PRESC_W'(TICK_DIV - 1));

    // Clear suppresses the increment, so tick/overflow stay low in a clear cycle.
    assign tick_now   = count_enb & ~init_rise & presc_last;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            init_d  <= 1'b0;
            latch_d <= 1'b0;
            running <= 1'b0;
        end else begin
            init_d  <= count_init;
            latch_d <= latch_count;
            running <= count_enb;
        end
    end

    // Prescaler holds while disabled so a pause keeps the sub-tick phase.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (init_rise) begin
            presc <= '0;
        end else if (count_enb) begin
            presc <= presc_last ? '0 : presc + PRESC_W'(1);
        end
    end

    bcd_digit_counter #(.MAX(DEC_MAX)) u_cs_u (
        .sys_clk(sys_clk), .reset_n(reset_n), .clr(init_rise),
        .inc(tick_now), .digit(d_cs_u), .carry(c_cs_u)
    );
    bcd_digit_counter #(.MAX(DEC_MAX)) u_cs_t (
        .sys_clk(sys_clk), .reset_n(reset_n), .clr(init_rise),
        .inc(c_cs_u), .digit(d_cs_t), .carry(c_cs_t)
    );
    bcd_digit_counter #(.MAX(DEC_MAX)) u_sec_u (
        .sys_clk(sys_clk), .reset_n(reset_n), .clr(init_rise),
        .inc(c_cs_t), .digit(d_sec_u), .carry(c_sec_u)
    );
    bcd_digit_counter #(.MAX(SEX_MAX)) u_sec_t (
        .sys_clk(sys_clk), .reset_n(reset_n), .clr(init_rise),
        .inc(c_sec_u), .digit(d_sec_t), .carry(c_sec_t)
    );
    bcd_digit_counter #(.MAX(DEC_MAX)) u_min_u (
        .sys_clk(sys_clk), .reset_n(reset_n), .clr(init_rise),
        .inc(c_sec_t), .digit(d_min_u), .carry(c_min_u)
    );
    bcd_digit_counter #(.MAX(SEX_MAX)) u_min_t (
        .sys_clk(sys_clk), .reset_n(reset_n), .clr(init_rise),
        .inc(c_min_u), .digit(d_min_t), .carry(c_min_t)
    );

    always_comb begin
        live_time = '0;
        live_time[CS_U_LSB  +: BCD_W] = d_cs_u;
        live_time[CS_T_LSB  +: BCD_W] = d_cs_t;
        live_time[SEC_U_LSB +: BCD_W] = d_sec_u;
        live_time[SEC_T_LSB +: BCD_W] = d_sec_t;
        live_time[MIN_U_LSB +: BCD_W] = d_min_u;
        live_time[MIN_T_LSB +: BCD_W] = d_min_t;
    end

    // Pulses register alongside the digits so they line up with the new value.
    // latched_time samples the pre-edge live_time, i.e. the pre-increment value.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            tick         <= 1'b0;
            overflow     <= 1'b0;
            latched_time <= '0;
        end else begin
            tick     <= tick_now;
            overflow <= c_min_t;
            if (latch_fall) begin
                latched_time <= live_time;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb/tb_stopwatch_counter.sv - self-checking bench for stopwatch_counter
module tb_stopwatch_counter;

    localparam int TD = 4;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        count_init = 1'b0;
    logic        count_enb = 1'b0;
    logic        latch_count = 1'b0;
    logic [23:0] live_time;
    logic [23:0] latched_time;
    logic        running;
    logic        tick;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: elapsed time as a plain centisecond count.
    int          m_time = 0;
    int          m_presc = 0;
    bit          m_pinit = 0;
    bit          m_platch = 0;
    logic [23:0] m_latched = '0;
    bit          m_tick = 0;
    bit          m_ovf = 0;
    bit          m_run = 0;

    typedef struct {
        logic        i;
        logic        e;
        logic        l;
        int          n;
        logic [23:0] live;
        logic [23:0] latched;
    } seg_t;

    seg_t tbl[9];

    stopwatch_counter #(.TICK_DIV(TD), .PRESC_W(3)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n),
        .count_init(count_init), .count_enb(count_enb), .latch_count(latch_count),
        .live_time(live_time), .latched_time(latched_time),
        .running(running), .tick(tick), .overflow(overflow)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [23:0] to_bcd(input int t);
        int m, s, c;
        m = t / 6000;
        s = (t / 100) % 60;
        c = t % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_time = 0; m_presc = 0; m_pinit = 0; m_platch = 0;
        m_latched = '0; m_tick = 0; m_ovf = 0; m_run = 0;
    endtask

    task automatic model_edge();
        bit rise, fall;
        rise = count_init & ~m_pinit;
        fall = ~latch_count & m_platch;
        m_tick = 0;
        m_ovf = 0;
        if (fall) m_latched = to_bcd(m_time);
        if (rise) begin
            m_time = 0;
            m_presc = 0;
        end else if (count_enb) begin
            if (m_presc == TD - 1) begin
                m_presc = 0;
                m_time = (m_time + 1) % 360000;
                m_tick = 1;
                m_ovf = (m_time == 0);
            end else begin
                m_presc++;
            end
        end
        m_run = count_enb;
        m_pinit = count_init;
        m_platch = latch_count;
    endtask

    task automatic step();
        model_edge();
        @(posedge sys_clk);
        #1;
        cyc++;
        check("cycle", {live_time, latched_time, running, tick, overflow},
                       {to_bcd(m_time), m_latched, m_run, m_tick, m_ovf});
    endtask

    task automatic set_in(input logic i, input logic e, input logic l);
        count_init = i;
        count_enb = e;
        latch_count = l;
    endtask

    task automatic run_seg(input seg_t s, input string name);
        set_in(s.i, s.e, s.l);
        for (int k = 0; k < s.n; k++) step();
        check(name, {live_time, latched_time}, {s.live, s.latched});
    endtask

    initial begin
        int n_ovf;
        int r;

        // Stimulus table: inputs held for n cycles, then live/latched expected.
        tbl[0] = '{0, 0, 0, 50,  24'h000000, 24'h000000};  // idle after reset
        tbl[1] = '{1, 1, 1, 41,  24'h000010, 24'h000000};  // start + 40 enabled
        tbl[2] = '{0, 0, 0, 1,   24'h000010, 24'h000010};  // stop
        tbl[3] = '{1, 1, 1, 23,  24'h000005, 24'h000010};  // start + 22 enabled
        tbl[4] = '{0, 0, 0, 1,   24'h000005, 24'h000005};  // stop captures 5
        tbl[5] = '{0, 1, 0, 2,   24'h000006, 24'h000005};  // resume keeps phase
        tbl[6] = '{0, 1, 1, 15,  24'h000009, 24'h000005};  // reach 9, prescaler at 3
        tbl[7] = '{0, 1, 0, 1,   24'h000010, 24'h000009};  // latch_fall with tick
        tbl[8] = '{0, 1, 0, 452, 24'h000123, 24'h000009};  // run up to 01.23

        repeat (3) @(posedge sys_clk);
        #1;
        reset_n = 1'b1;
        check("reset_state", {live_time, latched_time, running, tick, overflow}, 64'h0);

        for (int s = 0; s < 9; s++) run_seg(tbl[s], $sformatf("seg%0d", s));

        // Asynchronous reset mid-run at 01.23, outputs clear before any edge.
        set_in(0, 0, 0);
        #2 reset_n = 1'b0;
        #1 check("async_reset", {live_time, latched_time, running, tick, overflow}, 64'h0);
        model_reset();
        @(posedge sys_clk);
        #1 reset_n = 1'b1;
        run_seg('{0, 0, 0, 5, 24'h000000, 24'h000000}, "post_reset_idle");
        run_seg('{1, 1, 1, 9, 24'h000002, 24'h000000}, "post_reset_start");

        // Wrap: preload 59:59.99 while paused, then count through the wrap.
        set_in(0, 0, 1);
        step();
        force dut.u_min_t.digit = 4'd5;
        force dut.u_min_u.digit = 4'd9;
        force dut.u_sec_t.digit = 4'd5;
        force dut.u_sec_u.digit = 4'd9;
        force dut.u_cs_t.digit  = 4'd9;
        force dut.u_cs_u.digit  = 4'd9;
        #1;
        release dut.u_min_t.digit;
        release dut.u_min_u.digit;
        release dut.u_sec_t.digit;
        release dut.u_sec_u.digit;
        release dut.u_cs_t.digit;
        release dut.u_cs_u.digit;
        m_time = 359999;
        check("preload", {40'h0, live_time}, {40'h0, 24'h595999});
        set_in(0, 1, 1);
        n_ovf = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (overflow) begin
                n_ovf++;
                check("ovf_wrap", {tick, live_time}, {1'b1, 24'h000000});
            end
        end
        check("ovf_once", n_ovf, 1);

        // Randomized run against the model.
        for (int k = 0; k < 1500; k++) begin
            r = $urandom_range(0, 99);
            count_init = (r < 4) ? ~count_init : count_init;
            count_enb = (r >= 12);
            if ($urandom_range(0, 9) == 0) latch_count = ~latch_count;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
